// File: rtl/reg_bank_pkg.sv
// Shared processor datapath constants: data width, default bank size and
// register index assignments used by the control unit.
package reg_bank_pkg;

  localparam int unsigned DATA_W       = 16;
  localparam int unsigned NUM_REGS_DEF = 8;

  localparam int unsigned REG_PC = 0;
  localparam int unsigned REG_AR = 1;
  localparam int unsigned REG_AC = 2;
  localparam int unsigned REG_IR = 3;
  localparam int unsigned REG_DR = 4;
  localparam int unsigned REG_TR = 5;

endpackage

// File: rtl/reg_bank_reg_cell.sv
// One register bank entry: synchronous active-low reset, load has priority
// over increment, exposes its next-state value for the read bypass.
module reg_cell #(
  parameter int unsigned      WIDTH       = 16,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             load,
  input  logic             inc,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q_next,
  output logic             carry_out
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  always_comb begin
    q_d       = q_q;
    carry_out = 1'b0;
    if (load) begin
      q_d = d;
    end else if (inc) begin
      q_d       = q_q + 1'b1;
      carry_out = &q_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      q_q <= RESET_VALUE;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_next = q_d;

endmodule

// File: rtl/reg_bank.sv
// Parametrised register bank: one write port, one increment port, two
// registered read ports with write-through bypass, gated by runEnable.
module reg_bank
  import reg_bank_pkg::*;
#(
  parameter int unsigned      WIDTH       = DATA_W,
  parameter int unsigned      NUM_REGS    = NUM_REGS_DEF,
  parameter int unsigned      ADDR_W      = $clog2(NUM_REGS),
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic              clk,
  input  logic              resetN,
  input  logic              runEnable,
  input  logic              writeEnable,
  input  logic [ADDR_W-1:0] writeAddr,
  input  logic [WIDTH-1:0]  dataIn,
  input  logic              incEnable,
  input  logic [ADDR_W-1:0] incAddr,
  input  logic [ADDR_W-1:0] readAddrA,
  input  logic [ADDR_W-1:0] readAddrB,
  output logic [WIDTH-1:0]  dataOutA,
  output logic [WIDTH-1:0]  dataOutB,
  output logic              zeroA,
  output logic              incWrap
);

  logic [NUM_REGS-1:0] load;
  logic [NUM_REGS-1:0] inc;
  logic [NUM_REGS-1:0] carry;
  logic [WIDTH-1:0]    nxt [NUM_REGS];

  logic [WIDTH-1:0] dout_a_q, dout_a_d;
  logic [WIDTH-1:0] dout_b_q, dout_b_d;
  logic             zero_a_q, zero_a_d;
  logic             inc_wrap_q, inc_wrap_d;

  // Decoding only indices below NUM_REGS makes out-of-range addresses no-ops.
  always_comb begin
    load = '0;
    inc  = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      load[i] = runEnable && writeEnable && (writeAddr == ADDR_W'(i));
      inc[i]  = runEnable && incEnable && (incAddr == ADDR_W'(i));
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_cell
    reg_cell #(
      .WIDTH       (WIDTH),
      .RESET_VALUE (RESET_VALUE)
    ) u_cell (
      .clk       (clk),
      .resetN    (resetN),
      .load      (load[g]),
      .inc       (inc[g]),
      .d         (dataIn),
      .q_next    (nxt[g]),
      .carry_out (carry[g])
    );
  end

  always_comb begin
    dout_a_d = '0;
    dout_b_d = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (readAddrA == ADDR_W'(i)) dout_a_d = nxt[i];
      if (readAddrB == ADDR_W'(i)) dout_b_d = nxt[i];
    end
    zero_a_d   = (dout_a_d == '0);
    inc_wrap_d = |carry;
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      dout_a_q   <= '0;
      dout_b_q   <= '0;
      zero_a_q   <= 1'b1;
      inc_wrap_q <= 1'b0;
    end else begin
      dout_a_q   <= dout_a_d;
      dout_b_q   <= dout_b_d;
      zero_a_q   <= zero_a_d;
      inc_wrap_q <= inc_wrap_d;
    end
  end

  assign dataOutA = dout_a_q;
  assign dataOutB = dout_b_q;
  assign zeroA    = zero_a_q;
  assign incWrap  = inc_wrap_q;

endmodule
